// File: rtl/float_pkg.sv
// Shared float32 types and constants for the integer/float conversion units.
package float_pkg;

  localparam int unsigned FLOAT_EXP_BIAS = 127;
  localparam int unsigned FLOAT_MANT_W   = 23;

  typedef struct packed {
    logic                    sign;
    logic [7:0]              exp;
    logic [FLOAT_MANT_W-1:0] mant;
  } float32_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_NORMALIZE,
    ST_ROUND
  } i2f_state_e;

endpackage

// File: rtl/leading_zero_count32.sv
// Combinational leading-zero counter; only used when INT_TO_FLOAT_FAST_NORM_EN is defined.
module leading_zero_count32 (
  input  logic [31:0] value,
  output logic [5:0]  count_c
);

  // Scan from LSB upward so the highest set bit has the final say.
  always_comb begin
    count_c = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count_c = 6'(31 - i);
    end
  end

endmodule

// File: rtl/int_to_float.sv
// Signed 32-bit integer to float32 converter, round-to-nearest-even.
// Define INT_TO_FLOAT_FAST_NORM_EN for single-cycle normalization via a leading-zero counter.
module int_to_float
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic [31:0] a_value_i,
  output logic [31:0] z_value_o,
  input  logic        exec_strobe_i,
  output logic        done_strobe_o,
  output logic        busy_o
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 9;
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(FLOAT_EXP_BIAS + WORD_W - 1);

  i2f_state_e        state_q, state_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic              sign_q, sign_d;
  logic [WORD_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  float32_t          z_q, z_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              round_up_c;
  logic [FLOAT_MANT_W:0] mant_rnd_c;
  logic [7:0]        exp_rnd_c;
  float32_t          res_c;

`ifdef INT_TO_FLOAT_FAST_NORM_EN
  logic [5:0] lz_c;

  leading_zero_count32 u_lzc (
    .value   (mag_q),
    .count_c (lz_c)
  );
`endif

  // Mantissa carry-out on round-up bumps the exponent and leaves the field at zero.
  assign round_up_c = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
  assign mant_rnd_c = {1'b0, mag_q[30:8]} + (FLOAT_MANT_W + 1)'(round_up_c);
  assign exp_rnd_c  = exp_q[7:0] + 8'(mant_rnd_c[FLOAT_MANT_W]);
  assign res_c      = (mag_q == '0) ? '0 : {sign_q, exp_rnd_c, mant_rnd_c[FLOAT_MANT_W-1:0]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    z_d     = z_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (exec_strobe_i) begin
          a_d     = a_value_i;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        sign_d  = a_q[WORD_W-1];
        mag_d   = a_q[WORD_W-1] ? WORD_W'(~a_q + WORD_W'(1)) : a_q;
        exp_d   = EXP_INIT;
        state_d = ST_NORMALIZE;
      end
      ST_NORMALIZE: begin
`ifdef INT_TO_FLOAT_FAST_NORM_EN
        mag_d   = mag_q << lz_c;
        exp_d   = exp_q - EXP_W'(lz_c);
        state_d = ST_ROUND;
`else
        if (mag_q[WORD_W-1] || (mag_q == '0)) begin
          state_d = ST_ROUND;
        end else begin
          mag_d = {mag_q[WORD_W-2:0], 1'b0};
          exp_d = exp_q - EXP_W'(1);
        end
`endif
      end
      ST_ROUND: begin
        z_d     = res_c;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      z_q     <= z_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign z_value_o     = z_q;
  assign done_strobe_o = done_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float; honours INT_TO_FLOAT_FAST_NORM_EN for latency.
module tb_int_to_float;

  logic        clk;
  logic        reset_n;
  logic [31:0] a_value;
  logic [31:0] z_value;
  logic        exec;
  logic        done;
  logic        busy;

  int n_vec;
  int n_err;

  int_to_float dut (
    .clk           (clk),
    .reset_n_i     (reset_n),
    .a_value_i     (a_value),
    .z_value_o     (z_value),
    .exec_strobe_i (exec),
    .done_strobe_o (done),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Exponent of the most significant set bit of a positive magnitude.
  function automatic int msb_pos(input longint m);
    int e;
    e = 0;
    for (int i = 0; i < 32; i++) if (m >= (longint'(1) << i)) e = i;
    return e;
  endfunction

  function automatic longint abs_mag(input logic [31:0] a);
    return a[31] ? (longint'(64'h1_0000_0000) - longint'(a)) : longint'(a);
  endfunction

  // Real-valued conversion with explicit round-half-to-even on the discarded tail.
  function automatic logic [31:0] ref_float(input logic [31:0] a);
    longint m, q, rem, half;
    int     e, sh;
    if (a == 32'd0) return 32'd0;
    m = abs_mag(a);
    e = msb_pos(m);
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {a[31], 8'(e + 127), 23'(q)};
  endfunction

  function automatic int ref_lat(input logic [31:0] a);
`ifdef INT_TO_FLOAT_FAST_NORM_EN
    return 3;
`else
    if (a == 32'd0) return 3;
    return 3 + (31 - msb_pos(abs_mag(a)));
`endif
  endfunction

  task automatic do_op(input logic [31:0] val, output logic [31:0] z, output int lat);
    @(negedge clk);
    a_value = val;
    exec    = 1'b1;
    @(posedge clk);
    #1 exec = 1'b0;
    lat = 0;
    z   = 32'hxxxx_xxxx;
    while (lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) begin
        z = z_value;
        break;
      end
    end
  endtask

  task automatic op_check(input string tag, input logic [31:0] val);
    logic [31:0] z;
    int          lat;
    do_op(val, z, lat);
    check({tag, "_z"}, z, ref_float(val));
    check({tag, "_lat"}, 32'(lat), 32'(ref_lat(val)));
  endtask

  logic [31:0] dir_val [8] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'd16777217, 32'd16777219, 32'd16777221};
  logic [31:0] dir_exp [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4F00_0000,
                               32'hCF00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0002};

  initial begin
    logic [31:0] z, v;
    int          lat, lat_first, ndone;
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    exec    = 1'b0;
    a_value = '0;
    #12;
    check("rst_z", z_value, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed values against fixed expectations.
    for (int i = 0; i < 8; i++) begin
      do_op(dir_val[i], z, lat);
      check($sformatf("dir%0d_z", i), z, dir_exp[i]);
      check($sformatf("dir%0d_lat", i), 32'(lat), 32'(ref_lat(dir_val[i])));
      @(posedge clk);
      #1;
      check($sformatf("dir%0d_pulse", i), 32'(done), 32'd0);
      check($sformatf("dir%0d_hold", i), z_value, dir_exp[i]);
    end

    // Back-to-back: each exec lands in the cycle the previous done is high.
    op_check("b2b_a", 32'd3);
    check("b2b_done_hi", 32'(done), 32'd1);
    op_check("b2b_b", 32'hFFFF_FFF9);

    // Randomized operands spread over all magnitudes.
    for (int i = 0; i < 150; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = 32'(-v);
      op_check($sformatf("rnd%0d", i), v);
    end

    // Exec while busy must be ignored.
    @(negedge clk);
    a_value = 32'd1;
    exec    = 1'b1;
    @(posedge clk);
    #1 exec = 1'b0;
    check("busy_hi", 32'(busy), 32'd1);
    @(negedge clk);
    a_value = 32'd5;
    exec    = 1'b1;
    @(posedge clk);
    #1 exec = 1'b0;
    lat = 1;
    ndone = 0;
    lat_first = 0;
    z = '0;
    while (lat < 80) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          z = z_value;
          lat_first = lat;
        end
      end
    end
    check("busy_ign_ndone", 32'(ndone), 32'd1);
    check("busy_ign_z", z, 32'h3F80_0000);
    check("busy_ign_lat", 32'(lat_first), 32'(ref_lat(32'd1)));

    // Reset during NORMALIZE aborts without a done pulse.
    @(negedge clk);
    a_value = 32'd1;
    exec    = 1'b1;
    @(posedge clk);
    #1 exec = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_z", z_value, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) ndone++;
    end
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("arst_ndone", 32'(ndone), 32'd0);
    do_op(32'd2, z, lat);
    check("arst_after_z", z, 32'h4000_0000);
    check("arst_after_lat", 32'(lat), 32'(ref_lat(32'd2)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
